// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus between the fetch stage (master) and the memory (slave).
// One request is outstanding at a time; mem_ack/mem_err only mean something while mem_req is high.
interface instruction_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_err,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_err,
    output mem_rdata
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: reads one instruction per PC over the memory bus, holds it for decode,
// and pulses the PC block's enable exactly once per instruction decode accepts.
module instruction_fetch #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         pc_in,
  output logic                pc_en,
  instruction_fetch_if.master mem,
  output logic [31:0]         instr_out,
  output logic [31:0]         instr_pc,
  output logic                instr_valid,
  input  logic                decode_ready,
  output logic                fetch_fault,
  output logic [CNT_W-1:0]    fetch_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       instr_out_q, instr_out_d;
  logic [31:0]       instr_pc_q, instr_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  // State register: every flop, including the held instruction, has a defined reset value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      instr_out_q <= NOP;
      instr_pc_q  <= '0;
      count_q     <= '0;
      to_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      instr_out_q <= instr_out_d;
      instr_pc_q  <= instr_pc_d;
      count_q     <= count_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    // NOTE: default every target first so no path through the case infers a latch.
    state_d     = state_q;
    instr_out_d = instr_out_q;
    instr_pc_d  = instr_pc_q;
    count_d     = count_q;
    to_cnt_d    = to_cnt_q;
    case (state_q)
      IDLE: begin
        state_d  = REQ;
        to_cnt_d = '0;
      end
      REQ: begin
        // A bus error beats a simultaneous ack: the returned word is not trusted.
        if (mem.mem_err) begin
          state_d = FAULT;
        end else if (mem.mem_ack) begin
          instr_out_d = mem.mem_rdata;
          instr_pc_d  = pc_in;
          state_d     = HOLD;
        end else if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
          state_d = FAULT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (decode_ready) begin
          count_d  = count_q + 1'b1;
          to_cnt_d = '0;
          state_d  = REQ;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure decodes of the state; pc_en is the decode handshake itself.
  always_comb begin
    mem.mem_req  = (state_q == REQ);
    mem.mem_addr = pc_in;
    instr_valid  = (state_q == HOLD);
    pc_en        = (state_q == HOLD) && decode_ready;
    fetch_fault  = (state_q == FAULT);
    instr_out    = instr_out_q;
    instr_pc     = instr_pc_q;
    fetch_count  = count_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a +4 PC model and a memory responder with
// configurable wait states drive the DUT; a second instance checks the no-timeout build.
module tb_instruction_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MASK = 32'hA5A5_A5A5;

  logic        clock;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_en;
  logic [31:0] instr_out, instr_pc;
  logic        instr_valid;
  logic        decode_ready;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic        pc_en0, instr_valid0, fetch_fault0;
  logic [31:0] instr_out0, instr_pc0, fetch_count0;

  instruction_fetch_if bus ();
  instruction_fetch_if bus0 ();

  instruction_fetch #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .pc_in        (pc_in),
    .pc_en        (pc_en),
    .mem          (bus),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .fetch_fault  (fetch_fault),
    .fetch_count  (fetch_count)
  );

  instruction_fetch #(.TIMEOUT(0), .CNT_W(32)) dut0 (
    .clock        (clock),
    .reset        (reset),
    .pc_in        (32'h0),
    .pc_en        (pc_en0),
    .mem          (bus0),
    .instr_out    (instr_out0),
    .instr_pc     (instr_pc0),
    .instr_valid  (instr_valid0),
    .decode_ready (1'b1),
    .fetch_fault  (fetch_fault0),
    .fetch_count  (fetch_count0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Responder controls
  int wait_cycles = 0;
  int wait_cnt    = 0;
  bit ack_en      = 1;
  bit force_ack   = 0;
  bit err_now     = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_mem();
    bus.mem_ack   = force_ack || (bus.mem_req && ack_en && (wait_cnt == wait_cycles));
    bus.mem_err   = err_now;
    bus.mem_rdata = bus.mem_addr ^ MASK;
  endtask

  // One clock: drive the memory, let the edge happen, then advance the PC model.
  task automatic cyc();
    bit en_s, req_s, ack_s;
    drive_mem();
    #1;
    en_s  = pc_en;
    req_s = bus.mem_req;
    ack_s = bus.mem_ack;
    @(posedge clock);
    #1;
    if (en_s) pc_in = pc_in + 32'd4;
    wait_cnt = (req_s && !ack_s) ? wait_cnt + 1 : 0;
    @(negedge clock);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   64'(bus.mem_req),  64'd0);
    check({tag, "_pcen"},  64'(pc_en),        64'd0);
    check({tag, "_valid"}, 64'(instr_valid),  64'd0);
    check({tag, "_instr"}, 64'(instr_out),    64'(NOP));
    check({tag, "_ipc"},   64'(instr_pc),     64'd0);
    check({tag, "_fault"}, 64'(fetch_fault),  64'd0);
    check({tag, "_count"}, 64'(fetch_count),  64'd0);
  endtask

  initial begin
    int n_req, bad;
    reset = 1'b1;
    pc_in = '0;
    decode_ready = 1'b1;
    bus.mem_ack = 0; bus.mem_err = 0; bus.mem_rdata = '0;
    bus0.mem_ack = 0; bus0.mem_err = 0; bus0.mem_rdata = '0;
    repeat (3) @(negedge clock);
    check_reset("rst0");

    // Zero-wait fetch of 0,4,8,12 with decode always ready
    reset = 1'b0;
    check("idle_req", 64'(bus.mem_req), 64'd0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("zw_addr%0d", k), 64'(bus.mem_addr), 64'(4 * k));
      check($sformatf("zw_req%0d", k),  64'(bus.mem_req),  64'd1);
      check($sformatf("zw_pcen_req%0d", k), 64'(pc_en),    64'd0);
      cyc();
      check($sformatf("zw_valid%0d", k), 64'(instr_valid), 64'd1);
      check($sformatf("zw_ipc%0d", k),   64'(instr_pc),    64'(4 * k));
      check($sformatf("zw_instr%0d", k), 64'(instr_out),   64'((4 * k) ^ MASK));
      check($sformatf("zw_pcen%0d", k),  64'(pc_en),       64'd1);
      cyc();
    end
    check("zw_count", 64'(fetch_count), 64'd4);

    // Three wait states at address 16; decode stalls once the word arrives
    wait_cycles = 3;
    decode_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ws_req%0d", i),   64'(bus.mem_req),  64'd1);
      check($sformatf("ws_addr%0d", i),  64'(bus.mem_addr), 64'd16);
      check($sformatf("ws_valid%0d", i), 64'(instr_valid),  64'd0);
      cyc();
    end
    check("ws_valid", 64'(instr_valid), 64'd1);
    check("ws_fault", 64'(fetch_fault), 64'd0);

    // Decode stall for five cycles: everything holds
    for (int i = 0; i < 5; i++) begin
      check($sformatf("st_valid%0d", i), 64'(instr_valid), 64'd1);
      check($sformatf("st_ipc%0d", i),   64'(instr_pc),    64'd16);
      check($sformatf("st_instr%0d", i), 64'(instr_out),   64'(32'd16 ^ MASK));
      check($sformatf("st_pcen%0d", i),  64'(pc_en),       64'd0);
      check($sformatf("st_req%0d", i),   64'(bus.mem_req), 64'd0);
      cyc();
    end
    decode_ready = 1'b1;
    #1;
    check("st_pcen_pulse", 64'(pc_en), 64'd1);
    cyc();
    check("st_pcen_after", 64'(pc_en),        64'd0);
    check("st_next_addr",  64'(bus.mem_addr), 64'd20);
    check("st_count",      64'(fetch_count),  64'd5);

    // Reset in the middle of a request; a stray ack arrives while in IDLE
    reset = 1'b1;
    pc_in = '0;
    #1;
    check("mid_rst_req", 64'(bus.mem_req), 64'd0);
    check_reset("rst1");
    @(negedge clock);
    force_ack = 1'b1;
    reset = 1'b0;
    cyc();
    force_ack = 1'b0;
    wait_cycles = 1;
    check("rr_valid0", 64'(instr_valid),  64'd0);
    check("rr_req",    64'(bus.mem_req),  64'd1);
    check("rr_addr",   64'(bus.mem_addr), 64'd0);
    cyc();
    check("rr_valid1", 64'(instr_valid),  64'd0);
    cyc();
    check("rr_valid2", 64'(instr_valid),  64'd1);
    check("rr_ipc",    64'(instr_pc),     64'd0);
    check("rr_instr",  64'(instr_out),    64'(MASK));

    // Error and ack together at PC 8
    wait_cycles = 0;
    cyc();
    cyc();
    cyc();
    check("er_addr", 64'(bus.mem_addr), 64'd8);
    check("er_req",  64'(bus.mem_req),  64'd1);
    err_now = 1'b1;
    cyc();
    err_now = 1'b0;
    check("er_fault", 64'(fetch_fault), 64'd1);
    check("er_valid", 64'(instr_valid), 64'd0);
    check("er_ipc",   64'(instr_pc),    64'd4);
    check("er_instr", 64'(instr_out),   64'(32'd4 ^ MASK));
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_req || pc_en || !fetch_fault) bad++;
      cyc();
    end
    check("er_parked", 64'(bad), 64'd0);
    reset = 1'b1;
    pc_in = '0;
    #1;
    check_reset("rst2");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Memory never answers: fault after exactly 16 request cycles
    ack_en = 1'b0;
    cyc();
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.mem_req) break;
      n_req++;
      cyc();
    end
    check("to_cycles", 64'(n_req),       64'd16);
    check("to_fault",  64'(fetch_fault), 64'd1);

    // The TIMEOUT=0 build keeps requesting
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus0.mem_req || fetch_fault0) bad++;
      cyc();
    end
    check("nto_waiting", 64'(bad),          64'd0);
    check("nto_fault",   64'(fetch_fault0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage sitting directly downstream of the program counter block. Takes the current PC, issues one instruction-memory read per instruction over a req/ack handshake and holds the fetched word for decode. Drives the PC block's enable (in_en) so the PC advances exactly once per instruction accepted by decode. Detects bus errors and fetch timeouts and parks in a fault state.

Parameters:
TIMEOUT, 16, max REQ cycles without mem_ack before fault; 0 disables timeout
CNT_W, 32, width of retired-fetch counter

Ports:
clock  in  1  system clock
reset  in  1  reset, asynchronous, active-high
pc_in  in  32  current PC from PC block (pc_out)
pc_en  out  1  advance enable to PC block (in_en)
mem_req  out  1  instruction memory read request
mem_addr  out  32  read address
mem_ack  in  1  read data valid / request complete
mem_err  in  1  bus error, qualified by mem_req
mem_rdata  in  32  read data
instr_out  out  32  fetched instruction to decode
instr_pc  out  32  PC of instr_out
instr_valid  out  1  instr_out valid
decode_ready  in  1  decode accepts instr_out
fetch_fault  out  1  sticky fault flag
fetch_count  out  CNT_W  number of instructions accepted by decode

Behaviour:
- Reset values: state=IDLE, mem_req=0, pc_en=0, instr_valid=0, instr_out=32'h00000013 (NOP), instr_pc=0, fetch_fault=0, fetch_count=0, timeout counter=0. Async reset mid-request drops mem_req immediately; any in-flight ack after reset release is ignored unless mem_req=1.
- States: IDLE, REQ, HOLD, FAULT.
- IDLE: one cycle after reset release, unconditional -> REQ.
- REQ: mem_req=1, mem_addr=pc_in (combinational; stable because pc_en=0 in REQ). Timeout counter cleared on entry, increments each REQ cycle without ack.
  - mem_err=1 -> FAULT (err wins over simultaneous ack; no data captured).
  - mem_ack=1 -> capture instr_out<=mem_rdata, instr_pc<=pc_in, instr_valid<=1, -> HOLD.
  - TIMEOUT!=0 and counter==TIMEOUT-1 and no ack/err -> FAULT.
- HOLD: instr_valid=1, mem_req=0. pc_en = decode_ready (combinational, only in HOLD). On decode_ready: instr_valid<=0, fetch_count<=fetch_count+1 (wraps at 2^CNT_W), -> REQ. PC updates on the same edge, so next REQ uses the new pc_in. Without decode_ready: stay, outputs stable.
- FAULT: fetch_fault=1, mem_req=0, instr_valid=0, pc_en=0; exit only by reset.
- mem_ack/mem_err with mem_req=0: ignored.
- decode_ready outside HOLD: ignored (no handshake, no pc_en).
- Latency: zero-wait memory (ack in first REQ cycle): REQ at cycle n, instr_valid at n+1; with decode_ready high, pc_en at n+1, next REQ at n+2. Peak throughput 1 instr / 2 cycles. Each memory wait cycle adds one.
- pc_en is never high for more than one cycle per accepted instruction; never high in IDLE/REQ/FAULT.

Test Plan:
- Reset, zero-wait memory returning addr^32'hA5A5A5A5, decode_ready=1, PC model +4 -> mem_addr sequence 0,4,8,12; instr_pc matches; pc_en pulses every 2nd cycle; fetch_count=4 after 4 handshakes.
- Memory with 3 wait cycles, TIMEOUT=16 -> mem_req high 4 cycles, mem_addr stable, instr_valid one cycle after ack, no fault.
- decode_ready held 0 for 5 cycles in HOLD -> instr_out/instr_pc/instr_valid stable, pc_en=0, mem_req=0; drop to 1 -> single pc_en pulse, count +1.
- mem_err and mem_ack same cycle at pc 0x8 -> FAULT, fetch_fault=1, instr_valid=0, no further mem_req until reset; reset -> all outputs to reset values.
- No ack, TIMEOUT=16 -> fault asserted after exactly 16 REQ cycles; TIMEOUT=0 build -> waits indefinitely (check 100 cycles).
- Assert reset mid-REQ with ack arriving after release while in IDLE -> ack ignored, fetch restarts from pc_in=0, instr_valid stays 0 until new ack.
